// File: rtl/avr_prefetch.sv
// rtl/avr_prefetch.sv - AVR instruction prefetch queue with two-word instruction assembly and redirect flush
module avr_prefetch #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            p_req,
  output logic [PC_W-1:0] p_addr,
  input  logic [15:0]     p_data,
  output logic            instr_valid,
  input  logic            dec_ready,
  output logic [15:0]     instr,
  output logic [15:0]     instr2,
  output logic            instr_long,
  output logic [PC_W-1:0] instr_pc,
  input  logic            redirect,
  input  logic            redirect_abs,
  input  logic [PC_W-1:0] redirect_val
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [15:0]     q_word [DEPTH];
  logic [PC_W-1:0] q_addr [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr1;
  logic [CW-1:0]   count, n_pop;
  logic            in_flight, push, pop, head_long;
  logic [PC_W-1:0] fl_addr, fetch_pc, last_pc, base_pc, target;

  function automatic logic is_long(input logic [15:0] w);
    return ((w & 16'hFE0E) == 16'h940C) || ((w & 16'hFE0E) == 16'h940E) ||
           ((w & 16'hFC0F) == 16'h9000);
  endfunction

  assign rd_ptr1     = rd_ptr + 1'b1;
  assign instr       = q_word[rd_ptr];
  assign instr2      = q_word[rd_ptr1];
  assign instr_pc    = q_addr[rd_ptr];
  assign head_long   = is_long(q_word[rd_ptr]);
  assign instr_long  = head_long;
  assign instr_valid = (count != '0) && (!head_long || count >= CW'(2));

  // In-flight word counts against capacity so its response always has a slot.
  assign p_req  = !RST && !redirect && ((count + {{AW{1'b0}}, in_flight}) < DEPTH_C);
  assign p_addr = fetch_pc;

  assign push  = in_flight && !redirect;
  assign pop   = instr_valid && dec_ready && !redirect;
  assign n_pop = pop ? (head_long ? CW'(2) : CW'(1)) : '0;

  // Relative targets fall back to the last presented PC when nothing is presented.
  assign base_pc = instr_valid ? instr_pc : last_pc;
  assign target  = redirect_abs ? redirect_val : (base_pc + PC_W'(1) + redirect_val);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      in_flight <= 1'b0;
      fl_addr   <= '0;
      fetch_pc  <= '0;
      last_pc   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_word[i] <= 16'h0000;
        q_addr[i] <= '0;
      end
    end else begin
      in_flight <= p_req;
      fl_addr   <= fetch_pc;
      if (instr_valid)
        last_pc <= instr_pc;
      if (redirect) begin
        count    <= '0;
        wr_ptr   <= rd_ptr;
        fetch_pc <= target;
      end else begin
        if (p_req)
          fetch_pc <= fetch_pc + PC_W'(1);
        if (push) begin
          q_word[wr_ptr] <= p_data;
          q_addr[wr_ptr] <= fl_addr;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        rd_ptr <= rd_ptr + n_pop[AW-1:0];
        count  <= count + {{AW{1'b0}}, push} - n_pop;
      end
    end
  end

endmodule

// File: tb/tb_avr_prefetch.sv
// tb/tb_avr_prefetch.sv - randomized and directed bench for avr_prefetch against a word-queue model
module tb_avr_prefetch;
  localparam int PC_W  = 16;
  localparam int DEPTH = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            p_req;
  logic [PC_W-1:0] p_addr;
  logic [15:0]     p_data = 16'h0000;
  logic            instr_valid;
  logic            dec_ready = 1'b0;
  logic [15:0]     instr, instr2;
  logic            instr_long;
  logic [PC_W-1:0] instr_pc;
  logic            redirect = 1'b0;
  logic            redirect_abs = 1'b0;
  logic [PC_W-1:0] redirect_val = '0;

  avr_prefetch #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .p_req(p_req), .p_addr(p_addr), .p_data(p_data),
    .instr_valid(instr_valid), .dec_ready(dec_ready), .instr(instr), .instr2(instr2),
    .instr_long(instr_long), .instr_pc(instr_pc), .redirect(redirect),
    .redirect_abs(redirect_abs), .redirect_val(redirect_val)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [0:65535];
  always @(posedge CLK) if (p_req) p_data <= mem[p_addr];

  int checks = 0;
  int errors = 0;

  // Model: addresses of words held by the unit, in program order.
  logic [PC_W-1:0] q [$];
  logic            pend_v;
  logic [PC_W-1:0] pend_a, next_fetch, last_pc;
  logic            obs_req, obs_valid, obs_long;
  logic [PC_W-1:0] obs_addr, obs_pc;
  logic [15:0]     obs_instr2;

  function automatic logic is_long(input logic [15:0] w);
    return ((w & 16'hFE0E) == 16'h940C) || ((w & 16'hFE0E) == 16'h940E) ||
           ((w & 16'hFC0F) == 16'h9000);
  endfunction

  task automatic cycle(input logic rdy, input logic rd, input logic ab, input logic [PC_W-1:0] val);
    logic ev, er;
    logic [PC_W-1:0] base, tgt;
    dec_ready = rdy; redirect = rd; redirect_abs = ab; redirect_val = val;
    #1;
    obs_req = p_req; obs_addr = p_addr; obs_valid = instr_valid;
    obs_pc = instr_pc; obs_long = instr_long; obs_instr2 = instr2;
    ev = (q.size() > 0) && (!is_long(mem[q[0]]) || q.size() > 1);
    er = !rd && ((q.size() + int'(pend_v)) < DEPTH);
    checks++;
    if (instr_valid !== ev) begin
      errors++; $display("FAIL instr_valid: got %b want %b at %0t", instr_valid, ev, $time);
    end
    if (ev && instr_valid) begin
      checks++;
      if (instr_pc !== q[0] || instr !== mem[q[0]] || instr_long !== is_long(mem[q[0]])) begin
        errors++;
        $display("FAIL head: got pc=%h w=%h long=%b want pc=%h w=%h long=%b", instr_pc, instr,
                 instr_long, q[0], mem[q[0]], is_long(mem[q[0]]));
      end
      if (is_long(mem[q[0]])) begin
        checks++;
        if (instr2 !== mem[q[1]]) begin
          errors++; $display("FAIL instr2: got %h want %h", instr2, mem[q[1]]);
        end
      end
    end
    checks++;
    if (p_req !== er) begin
      errors++; $display("FAIL p_req: got %b want %b at %0t", p_req, er, $time);
    end
    if (p_req && er) begin
      checks++;
      if (p_addr !== next_fetch) begin
        errors++; $display("FAIL p_addr: got %h want %h", p_addr, next_fetch);
      end
    end
    base = ev ? q[0] : last_pc;
    if (ev) last_pc = q[0];
    if (rd) begin
      tgt = ab ? val : base + 16'd1 + val;
      q.delete(); pend_v = 1'b0; next_fetch = tgt;
    end else begin
      if (ev && rdy) begin
        if (is_long(mem[q[0]])) void'(q.pop_front());
        void'(q.pop_front());
      end
      if (pend_v) q.push_back(pend_a);
      pend_v = er; pend_a = next_fetch;
      if (er) next_fetch = next_fetch + 16'd1;
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1; redirect = 1'b0; dec_ready = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
    checks++;
    if (p_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0 || instr2 !== 16'h0 ||
        instr_long !== 1'b0 || instr_pc !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got req=%b v=%b i=%h i2=%h l=%b pc=%h want all zero",
               p_req, instr_valid, instr, instr2, instr_long, instr_pc);
    end
    q.delete(); pend_v = 1'b0; pend_a = '0; next_fetch = '0; last_pc = '0;
    RST = 1'b0;
  endtask

  task automatic mem_identity();
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i);
  endtask

  task automatic test_reset();
    do_reset(3);
  endtask

  task automatic test_stream();
    int first_v;
    do_reset(2);
    first_v = -1;
    for (int c = 0; c < 20; c++) begin
      cycle(1, 0, 0, '0);
      if (c == 0) begin
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 16'h0) begin
          errors++; $display("FAIL first_req: got req=%b addr=%h want 1 0000", obs_req, obs_addr);
        end
      end
      if (obs_valid && first_v < 0) first_v = c;
    end
    checks++;
    if (first_v != 2) begin errors++; $display("FAIL first_valid_cycle: got %0d want 2", first_v); end
  endtask

  task automatic test_backpressure();
    int nreq;
    do_reset(2);
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(0, 0, 0, '0);
      if (obs_req) nreq++;
    end
    checks++;
    if (nreq != DEPTH) begin errors++; $display("FAIL bp_requests: got %0d want %0d", nreq, DEPTH); end
    checks++;
    if (obs_pc !== 16'h0 || obs_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got pc=%h v=%b want 0000 1", obs_pc, obs_valid);
    end
    repeat (12) cycle(1, 0, 0, '0);
  endtask

  task automatic test_long();
    logic [PC_W-1:0] pcs [$];
    logic got_long;
    logic [15:0] got_i2;
    mem[0] = 16'h940C; mem[1] = 16'h0010;
    do_reset(2);
    got_long = 1'b0; got_i2 = '0;
    for (int c = 0; c < 12; c++) begin
      cycle(1, 0, 0, '0);
      if (obs_valid) begin
        if (pcs.size() == 0) begin got_long = obs_long; got_i2 = obs_instr2; end
        pcs.push_back(obs_pc);
      end
    end
    checks++;
    if (pcs.size() < 2 || pcs[0] !== 16'h0 || pcs[1] !== 16'h2 || got_long !== 1'b1 ||
        got_i2 !== 16'h0010) begin
      errors++;
      $display("FAIL long_instr: got n=%0d long=%b i2=%h want pcs 0,2 long=1 i2=0010",
               pcs.size(), got_long, got_i2);
    end
    mem[0] = 16'h0000; mem[1] = 16'h0001;
  endtask

  task automatic test_rel_redirect();
    logic [PC_W-1:0] nxt;
    do_reset(2);
    for (int i = 0; i < 30 && !(instr_valid && instr_pc == 16'h5); i++) cycle(1, 0, 0, '0);
    cycle(1, 1, 0, 16'hFFFD);
    cycle(1, 0, 0, '0);
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 16'h3) begin
      errors++; $display("FAIL rel_target: got req=%b addr=%h want 1 0003", obs_req, obs_addr);
    end
    nxt = 16'hFFFF;
    for (int c = 0; c < 10; c++) begin
      cycle(1, 0, 0, '0);
      if (obs_valid && nxt == 16'hFFFF) nxt = obs_pc;
    end
    checks++;
    if (nxt !== 16'h3) begin errors++; $display("FAIL rel_next_pc: got %h want 0003", nxt); end
  endtask

  task automatic test_abs_redirect();
    logic [PC_W-1:0] nxt;
    do_reset(2);
    for (int i = 0; i < 30 && !(obs_req && obs_addr == 16'h7); i++) cycle(1, 0, 0, '0);
    cycle(1, 1, 1, 16'h0100);
    nxt = 16'hFFFF;
    for (int c = 0; c < 10; c++) begin
      cycle(1, 0, 0, '0);
      if (obs_valid && nxt == 16'hFFFF) nxt = obs_pc;
    end
    checks++;
    if (nxt !== 16'h0100) begin errors++; $display("FAIL abs_next_pc: got %h want 0100", nxt); end
  endtask

  task automatic test_wrap_and_reset();
    logic [PC_W-1:0] pcs [$];
    repeat (3) cycle(1, 0, 0, '0);
    cycle(1, 1, 1, 16'hFFFE);
    for (int c = 0; c < 10; c++) begin
      cycle(1, 0, 0, '0);
      if (obs_valid) pcs.push_back(obs_pc);
    end
    checks++;
    if (pcs.size() < 3 || pcs[0] !== 16'hFFFE || pcs[1] !== 16'hFFFF || pcs[2] !== 16'h0000) begin
      errors++; $display("FAIL wrap: got n=%0d want pcs FFFE FFFF 0000", pcs.size());
    end
    repeat (8) cycle(0, 0, 0, '0);
    do_reset(1);
    repeat (10) cycle(1, 0, 0, '0);
  endtask

  task automatic test_random();
    do_reset(2);
    RST = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 5) == 0) mem[i] = 16'h940C | (16'($urandom) & 16'h01F1);
      else if ($urandom_range(0, 9) == 0) mem[i] = 16'h9000 | (16'($urandom) & 16'h03F0);
    end
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0)
        cycle(1'($urandom), 1'b1, 1'($urandom), 16'($urandom_range(0, 40)) - 16'd20);
      else
        cycle($urandom_range(0, 3) != 0, 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    mem_identity();
    test_reset();
    test_stream();
    test_backpressure();
    test_long();
    test_rel_redirect();
    test_abs_redirect();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/avr_prefetch.md
Name: avr_prefetch

Overview:
Parametrised instruction fetch unit for the AVR core, replacing the single-register fetch stage. It streams program words from synchronous program memory into a DEPTH-entry prefetch queue and presents whole instructions to the decoder under a valid/ready handshake. Two-word instructions (JMP/CALL/LDS/STS) are presented as one unit. Absolute and PC-relative redirects flush the queue and discard in-flight reads.

Parameters:
PC_W, 16, program counter / program address width in words
DEPTH, 4, prefetch queue entries in 16-bit words; power of 2, minimum 2

Ports:
CLK  input  1  clock
RST  input  1  reset, synchronous, active-high
p_req  output  1  program memory read request this cycle
p_addr  output  PC_W  word address for p_req
p_data  input  16  read data, valid exactly 1 cycle after p_req
instr_valid  output  1  instr/instr2/instr_pc hold a complete instruction
dec_ready  input  1  decoder accepts the presented instruction
instr  output  16  first instruction word
instr2  output  16  second word; meaningful only when instr_long=1
instr_long  output  1  presented instruction is two words
instr_pc  output  PC_W  word address of instr
redirect  input  1  flush and change fetch PC
redirect_abs  input  1  1: target = redirect_val; 0: target = instr_pc + 1 + redirect_val
redirect_val  input  PC_W  absolute target, or two's-complement offset

Behaviour:
- Reset: fetch_pc=0, queue empty, in-flight flag cleared, p_req=0, instr_valid=0, instr=16'h0000 (NOP), instr2=0, instr_long=0, instr_pc=0. Reset mid-operation also drops any pending p_data.
- Each queue entry holds {word, addr}.
- Issue rule: p_req=1 when (occupancy + in_flight) < DEPTH and no redirect is asserted in this cycle. p_addr=fetch_pc. On issue, fetch_pc <= fetch_pc+1, modulo 2^PC_W (0xFFFF wraps to 0x0000).
- Response: p_data, tagged with the issued address, is pushed at the end of the cycle after the issue. The sustained rate is 1 word per cycle.
- Latency: a request issued in cycle n is written in cycle n+1 and produces instr_valid in cycle n+2 at the earliest. After RST deasserts, the first p_req (addr 0) comes in the first non-reset cycle.
- Long-instruction detect on the head word: (w & 16'hFE0E)==16'h940C (JMP), (w & 16'hFE0E)==16'h940E (CALL), or (w & 16'hFC0F)==16'h9000 (LDS/STS).
- instr_valid = head present AND (head not long OR second entry present). instr/instr2/instr_pc/instr_long come straight from queue head entries, with no extra register stage.
- A long instruction at the queue head with DEPTH=2 is still presentable: the issue rule guarantees both words are fetched.
- Consume: instr_valid & dec_ready pops 1 word, or 2 when instr_long. A pop and a push in the same cycle are both honoured; occupancy changes by push−pop.
- Outputs are stable while instr_valid=1 and dec_ready=0.
- Redirect, sampled at the clock edge:
  - Target is computed from the current instr_pc, mod 2^PC_W. A relative redirect with instr_valid=0 uses the last presented instr_pc.
  - Queue is cleared. A response due next cycle is discarded. fetch_pc <= target. No p_req in the redirect cycle.
  - Next cycle: p_req=1, p_addr=target. instr_valid=0 for at least 2 cycles after the redirect edge.
- Redirect has priority over consume in the same cycle: the instruction counts as accepted, but no pop side-effects remain after the flush.
- Back-to-back redirects: the last one wins. Each redirect discards the preceding cycle's in-flight response.
- When full (occupancy==DEPTH), p_req=0 until a pop frees space.

Test Plan:
- Reset/stream: mem[i]=16'h0000+i, dec_ready=1, release RST at cycle 0 -> p_req addr 0,1,2…; instr_valid from cycle 2; instr_pc 0,1,2… one per cycle, instr==instr_pc.
- Backpressure: DEPTH=4, dec_ready=0 -> exactly 4 requests (addr 0–3), then p_req=0. Outputs hold instr_pc=0. Raising dec_ready resumes one per cycle with no lost or duplicated word.
- Long instruction: mem[0]=16'h940C, mem[1]=16'h0010 -> single presentation with instr_long=1, instr2=16'h0010, instr_pc=0. The next presentation has instr_pc=2.
- Relative redirect: at instr_pc=5, redirect=1, redirect_abs=0, redirect_val=16'hFFFD -> next p_addr=3. Words 6+ already queued or in flight never appear. Next instr_pc=3.
- Absolute redirect with a concurrent response: redirect_val=16'h0100 in the cycle after a p_req to addr 7 -> word 7 is discarded. Next presented instr_pc=16'h0100.
- Wrap and reset mid-stream: absolute redirect to 16'hFFFE streams instr_pc FFFE, FFFF, 0000. Asserting RST while the queue is full -> next cycle instr_valid=0, p_req=0; after release, fetch restarts at addr 0.
